// File: rtl/imager_tx.sv
// Stream-to-parallel video transmitter: rebuilds fv/lv/dvo sensor timing from dv/dtype/data
// words, regenerating blanking and back-pressuring the stream while blanking.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd0
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'd2
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'd3
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd6
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'd7
`endif

module imager_tx #(
    parameter int PIXEL_WIDTH = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int DIM_WIDTH   = 16
) (
    input  logic                    clki,
    input  logic                    resetb_clki,
    input  logic                    enable,
    input  logic                    left_justify,
    input  logic [DIM_WIDTH-1:0]    vlead,
    input  logic [DIM_WIDTH-1:0]    hblank,
    input  logic [DIM_WIDTH-1:0]    vtrail,
    input  logic [DIM_WIDTH-1:0]    vblank,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]   datai,
    output logic                    stall,
    output logic                    fv,
    output logic                    lv,
    output logic                    dvo,
    output logic [PIXEL_WIDTH-1:0]  datao,
    output logic [15:0]             frame_count,
    output logic                    protocol_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_WAIT_ROW, S_ROW, S_HBLANK, S_TRAIL, S_VBLANK
    } state_t;

    state_t                   state_reg, state_next;
    logic [DIM_WIDTH-1:0]     cnt_reg, cnt_next;
    logic [15:0]              frame_count_reg, frame_count_next;
    logic                     err_reg, err_next;
    logic                     fv_reg, fv_next;
    logic                     lv_reg, lv_next;
    logic                     dvo_reg, dvo_next;
    logic [PIXEL_WIDTH-1:0]   datao_reg, datao_next;
    logic                     blank_state;
    logic                     xfer;
    logic [PIXEL_WIDTH-1:0]   pixel;

    // Counter holds (clocks - 1) so a zero setting still yields one clock of blanking.
    function automatic logic [DIM_WIDTH-1:0] blank_load(input logic [DIM_WIDTH-1:0] n);
        return (n == '0) ? '0 : n - DIM_WIDTH'(1);
    endfunction

    assign blank_state = (state_reg == S_LEAD) || (state_reg == S_HBLANK) ||
                         (state_reg == S_TRAIL) || (state_reg == S_VBLANK);
    assign stall = enable && blank_state;
    assign xfer  = dvi && !stall;
    assign pixel = left_justify ? datai[DATA_WIDTH-1 -: PIXEL_WIDTH] : datai[PIXEL_WIDTH-1:0];

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        frame_count_next = frame_count_reg;
        err_next         = err_reg;
        dvo_next         = 1'b0;
        datao_next       = '0;
        if (!enable) begin
            state_next = S_IDLE;
            err_next   = 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (xfer && dtypei == `DTYPE_FRAME_START) begin
                        state_next       = S_LEAD;
                        cnt_next         = blank_load(vlead);
                        frame_count_next = frame_count_reg + 16'd1;
                    end else if (xfer && dtypei == `DTYPE_PIXEL) begin
                        err_next = 1'b1;
                    end
                end
                S_LEAD, S_HBLANK: begin
                    if (cnt_reg == '0) state_next = S_WAIT_ROW;
                    else               cnt_next   = cnt_reg - DIM_WIDTH'(1);
                end
                S_TRAIL: begin
                    if (cnt_reg == '0) begin
                        state_next = S_VBLANK;
                        cnt_next   = blank_load(vblank);
                    end else begin
                        cnt_next = cnt_reg - DIM_WIDTH'(1);
                    end
                end
                S_VBLANK: begin
                    if (cnt_reg == '0) state_next = S_IDLE;
                    else               cnt_next   = cnt_reg - DIM_WIDTH'(1);
                end
                S_WAIT_ROW: begin
                    if (xfer) begin
                        case (dtypei)
                            `DTYPE_ROW_START: state_next = S_ROW;
                            `DTYPE_PIXEL: begin
                                state_next = S_ROW;
                                dvo_next   = 1'b1;
                                datao_next = pixel;
                            end
                            `DTYPE_FRAME_END: begin
                                state_next = S_TRAIL;
                                cnt_next   = blank_load(vtrail);
                            end
                            `DTYPE_FRAME_START: err_next = 1'b1;
                            default: ;
                        endcase
                    end
                end
                S_ROW: begin
                    if (xfer) begin
                        case (dtypei)
                            `DTYPE_PIXEL: begin
                                dvo_next   = 1'b1;
                                datao_next = pixel;
                            end
                            `DTYPE_ROW_END: begin
                                state_next = S_HBLANK;
                                cnt_next   = blank_load(hblank);
                            end
                            `DTYPE_FRAME_END: begin
                                state_next = S_TRAIL;
                                cnt_next   = blank_load(vtrail);
                            end
                            `DTYPE_ROW_START, `DTYPE_FRAME_START: err_next = 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
        fv_next = (state_next != S_IDLE) && (state_next != S_VBLANK);
        lv_next = (state_next == S_ROW);
    end

    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            frame_count_reg <= '0;
            err_reg         <= 1'b0;
            fv_reg          <= 1'b0;
            lv_reg          <= 1'b0;
            dvo_reg         <= 1'b0;
            datao_reg       <= '0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            frame_count_reg <= frame_count_next;
            err_reg         <= err_next;
            fv_reg          <= fv_next;
            lv_reg          <= lv_next;
            dvo_reg         <= dvo_next;
            datao_reg       <= datao_next;
        end
    end

    assign fv           = fv_reg;
    assign lv           = lv_reg;
    assign dvo          = dvo_reg;
    assign datao        = datao_reg;
    assign frame_count  = frame_count_reg;
    assign protocol_err = err_reg;

endmodule

// File: tb/tb_imager_tx.sv
// Directed self-checking bench for imager_tx: framing, blanking, justification,
// headers, protocol errors, disable and asynchronous reset.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 4'd0
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 4'd1
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 4'd2
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 4'd3
`endif
`ifndef DTYPE_PIXEL
`define DTYPE_PIXEL 4'd4
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 4'd5
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 4'd6
`endif
`ifndef DTYPE_HEADER_END
`define DTYPE_HEADER_END 4'd7
`endif

module tb_imager_tx;

    logic                    clki = 1'b0;
    logic                    resetb_clki;
    logic                    enable;
    logic                    left_justify;
    logic [15:0]             vlead, hblank, vtrail, vblank;
    logic                    dvi;
    logic [`DTYPE_WIDTH-1:0] dtypei;
    logic [15:0]             datai;
    logic                    stall, fv, lv, dvo, protocol_err;
    logic [11:0]             datao;
    logic [15:0]             frame_count;

    int checks = 0;
    int errors = 0;

    // Monitor state, sampled on the falling edge
    logic [11:0] pix_q[$];
    int lv_rises = 0;
    int gap = 0;
    int last_gap = 0;
    int activity = 0;
    logic lv_prev = 1'b0;

    imager_tx dut (
        .clki(clki), .resetb_clki(resetb_clki), .enable(enable),
        .left_justify(left_justify), .vlead(vlead), .hblank(hblank),
        .vtrail(vtrail), .vblank(vblank), .dvi(dvi), .dtypei(dtypei),
        .datai(datai), .stall(stall), .fv(fv), .lv(lv), .dvo(dvo),
        .datao(datao), .frame_count(frame_count), .protocol_err(protocol_err)
    );

    always #5 clki = ~clki;

    always @(negedge clki) begin
        if (lv) begin
            if (!lv_prev) begin
                lv_rises++;
                last_gap = gap;
            end
            gap = 0;
        end else begin
            gap++;
        end
        lv_prev = lv;
        if (dvo) pix_q.push_back(datao);
        if (fv || lv || dvo) activity++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    // Presents one word and holds it until accepted; returns stalled cycles.
    task automatic send(input logic [`DTYPE_WIDTH-1:0] t, input logic [15:0] d, output int waited);
        bit acc;
        waited = 0;
        dtypei = t;
        datai  = d;
        dvi    = 1'b1;
        do begin
            acc = !stall;
            if (!acc) waited++;
            @(posedge clki);
            #1;
        end while (!acc && waited < 64);
        dvi = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: type=%0d still stalled after %0d cycles, required accept", t, waited);
        end
        $display("xfer type=%0d data=%h waited=%0d fv=%b lv=%b dvo=%b datao=%h", t, d, waited, fv, lv, dvo, datao);
    endtask

    task automatic drain();
        int n = 0;
        while ((stall || fv) && n < 64) begin
            n++;
            tick(1);
        end
        checks++;
        if (stall || fv) begin
            errors++;
            $display("FAIL drain_timeout: stall=%b fv=%b, required both 0", stall, fv);
        end
    endtask

    task automatic test_reset();
        resetb_clki = 1'b0;
        #2;
        checks++;
        if ({fv, lv, dvo, stall, protocol_err, datao, frame_count} !== 33'd0) begin
            errors++;
            $display("FAIL reset_values: fv=%b lv=%b dvo=%b stall=%b err=%b datao=%h fc=%0d, required all 0",
                     fv, lv, dvo, stall, protocol_err, datao, frame_count);
        end
        tick(2);
        resetb_clki = 1'b1;
        tick(2);
        checks++;
        if ({fv, lv, dvo, stall} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_idle: fv/lv/dvo/stall=%b%b%b%b, required 0000", fv, lv, dvo, stall);
        end
    endtask

    task automatic test_basic_frame();
        int w, n;
        logic [11:0] exp_q[$];
        vlead = 16'd2; hblank = 16'd3; vtrail = 16'd1; vblank = 16'd4;
        left_justify = 1'b0;
        lv_rises = 0;
        pix_q.delete();
        send(`DTYPE_FRAME_START, 16'h0, w);
        checks++;
        if ({fv, lv, dvo, stall} !== 4'b1001) begin
            errors++;
            $display("FAIL basic_fs: fv/lv/dvo/stall=%b%b%b%b, required 1001", fv, lv, dvo, stall);
        end
        for (int r = 0; r < 2; r++) begin
            send(`DTYPE_ROW_START, 16'h0, w);
            checks++;
            if (w !== (r == 0 ? 2 : 3)) begin
                errors++;
                $display("FAIL basic_rs_wait: row %0d waited %0d, required %0d", r, w, (r == 0 ? 2 : 3));
            end
            checks++;
            if ({fv, lv, dvo} !== 3'b110) begin
                errors++;
                $display("FAIL basic_rs_lv: fv/lv/dvo=%b%b%b, required 110", fv, lv, dvo);
            end
            for (int i = 0; i < 3; i++) begin
                send(`DTYPE_PIXEL, 16'h0100 * (r + 1) + 16'(i), w);
                exp_q.push_back(12'h100 * 12'(r + 1) + 12'(i));
                checks++;
                if ({dvo, datao} !== {1'b1, exp_q[$]}) begin
                    errors++;
                    $display("FAIL basic_pix: dvo=%b datao=%h, required 1 %h", dvo, datao, exp_q[$]);
                end
            end
            send(`DTYPE_ROW_END, 16'h0, w);
            checks++;
            if ({fv, lv, dvo, stall} !== 4'b1001) begin
                errors++;
                $display("FAIL basic_re: fv/lv/dvo/stall=%b%b%b%b, required 1001", fv, lv, dvo, stall);
            end
        end
        send(`DTYPE_FRAME_END, 16'h0, w);
        checks++;
        if (w !== 3 || {fv, lv, stall} !== 3'b101) begin
            errors++;
            $display("FAIL basic_fe: waited=%0d fv/lv/stall=%b%b%b, required 3 101", w, fv, lv, stall);
        end
        tick(1);
        checks++;
        if ({fv, stall} !== 2'b01) begin
            errors++;
            $display("FAIL basic_trail: fv/stall=%b%b, required 01", fv, stall);
        end
        n = 0;
        while (stall && n < 64) begin
            n++;
            tick(1);
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL basic_vblank_len: %0d stall clocks, required 4", n);
        end
        checks++;
        if (frame_count !== 16'd1 || lv_rises !== 2 || last_gap !== 4) begin
            errors++;
            $display("FAIL basic_counts: fc=%0d lv_rises=%0d gap=%0d, required 1 2 4", frame_count, lv_rises, last_gap);
        end
        checks++;
        if (pix_q.size() !== 6) begin
            errors++;
            $display("FAIL basic_pix_count: %0d pixels, required 6", pix_q.size());
        end
        for (int i = 0; i < 6 && i < pix_q.size(); i++) begin
            checks++;
            if (pix_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_pix_order[%0d]: got %h, required %h", i, pix_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_implicit();
        int w;
        vlead = 16'd1; hblank = 16'd5; vtrail = 16'd2; vblank = 16'd1;
        lv_rises = 0;
        send(`DTYPE_FRAME_START, 16'h0, w);
        send(`DTYPE_PIXEL, 16'h0AAA, w);
        checks++;
        if (w !== 1 || {fv, lv, dvo, datao} !== {3'b111, 12'hAAA}) begin
            errors++;
            $display("FAIL implicit_start: waited=%0d fv/lv/dvo=%b%b%b datao=%h, required 1 111 aaa", w, fv, lv, dvo, datao);
        end
        send(`DTYPE_PIXEL, 16'h0555, w);
        checks++;
        if ({fv, lv, dvo, datao} !== {3'b111, 12'h555}) begin
            errors++;
            $display("FAIL implicit_pix2: fv/lv/dvo=%b%b%b datao=%h, required 111 555", fv, lv, dvo, datao);
        end
        send(`DTYPE_FRAME_END, 16'h0, w);
        checks++;
        if ({fv, lv, dvo, stall} !== 4'b1001) begin
            errors++;
            $display("FAIL implicit_end: fv/lv/dvo/stall=%b%b%b%b, required 1001", fv, lv, dvo, stall);
        end
        tick(1);
        checks++;
        if ({fv, stall} !== 2'b11) begin
            errors++;
            $display("FAIL implicit_trail2: fv/stall=%b%b, required 11", fv, stall);
        end
        tick(1);
        checks++;
        if ({fv, stall} !== 2'b01) begin
            errors++;
            $display("FAIL implicit_vblank: fv/stall=%b%b, required 01", fv, stall);
        end
        tick(1);
        checks++;
        if ({fv, stall, protocol_err} !== 3'b000 || frame_count !== 16'd2 || lv_rises !== 1) begin
            errors++;
            $display("FAIL implicit_done: fv/stall/err=%b%b%b fc=%0d lv_rises=%0d, required 000 2 1",
                     fv, stall, protocol_err, frame_count, lv_rises);
        end
    endtask

    task automatic test_justify();
        int w;
        logic [15:0] din[4]  = '{16'hABC0, 16'h0ABC, 16'h1234, 16'h1234};
        logic        lj[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [11:0] dexp[4] = '{12'hABC, 12'hABC, 12'h123, 12'h234};
        vlead = 16'd1; hblank = 16'd1; vtrail = 16'd1; vblank = 16'd1;
        send(`DTYPE_FRAME_START, 16'h0, w);
        for (int i = 0; i < 4; i++) begin
            left_justify = lj[i];
            send(`DTYPE_PIXEL, din[i], w);
            checks++;
            if ({dvo, datao} !== {1'b1, dexp[i]}) begin
                errors++;
                $display("FAIL justify[%0d]: lj=%b datai=%h dvo=%b datao=%h, required 1 %h", i, lj[i], din[i], dvo, datao, dexp[i]);
            end
        end
        left_justify = 1'b0;
        send(`DTYPE_FRAME_END, 16'h0, w);
        drain();
    endtask

    task automatic test_headers();
        int w, stalls;
        stalls = 0;
        activity = 0;
        send(`DTYPE_HEADER_START, 16'h1111, w);
        stalls += w;
        for (int i = 0; i < 5; i++) begin
            send(`DTYPE_HEADER, 16'(i), w);
            stalls += w;
        end
        send(`DTYPE_HEADER_END, 16'h2222, w);
        stalls += w;
        tick(2);
        checks++;
        if (activity !== 0 || stalls !== 0 || protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL headers_quiet: activity=%0d stalls=%0d err=%b, required 0 0 0", activity, stalls, protocol_err);
        end
        send(`DTYPE_PIXEL, 16'h0123, w);
        checks++;
        if ({protocol_err, fv, dvo} !== 3'b100) begin
            errors++;
            $display("FAIL idle_pixel_err: err/fv/dvo=%b%b%b, required 100", protocol_err, fv, dvo);
        end
    endtask

    task automatic test_errors_and_disable();
        int w;
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b, required 0", protocol_err);
        end
        send(`DTYPE_FRAME_START, 16'h0, w);
        send(`DTYPE_ROW_START, 16'h0, w);
        send(`DTYPE_ROW_START, 16'h0, w);
        checks++;
        if ({protocol_err, lv} !== 2'b11) begin
            errors++;
            $display("FAIL rs_in_row: err/lv=%b%b, required 11", protocol_err, lv);
        end
        send(`DTYPE_PIXEL, 16'h0077, w);
        // Disable coincides with a pixel transfer: the pixel must be discarded
        dtypei = `DTYPE_PIXEL;
        datai  = 16'h0088;
        dvi    = 1'b1;
        enable = 1'b0;
        tick(1);
        dvi = 1'b0;
        checks++;
        if ({fv, lv, dvo, stall, protocol_err, datao} !== 17'd0 || frame_count !== 16'd4) begin
            errors++;
            $display("FAIL disable: fv/lv/dvo/stall/err=%b%b%b%b%b datao=%h fc=%0d, required 00000 000 4",
                     fv, lv, dvo, stall, protocol_err, datao, frame_count);
        end
        send(`DTYPE_FRAME_START, 16'h0, w);
        checks++;
        if (fv !== 1'b0 || frame_count !== 16'd4 || w !== 0) begin
            errors++;
            $display("FAIL disabled_flush: fv=%b fc=%0d waited=%0d, required 0 4 0", fv, frame_count, w);
        end
        enable = 1'b1;
        send(`DTYPE_PIXEL, 16'h0011, w);
        send(`DTYPE_PIXEL, 16'h0022, w);
        checks++;
        if ({fv, lv, dvo} !== 3'b000) begin
            errors++;
            $display("FAIL reenable_pixels: fv/lv/dvo=%b%b%b, required 000", fv, lv, dvo);
        end
        send(`DTYPE_FRAME_START, 16'h0, w);
        checks++;
        if ({fv, stall} !== 2'b11 || frame_count !== 16'd5) begin
            errors++;
            $display("FAIL reenable_fs: fv/stall=%b%b fc=%0d, required 11 5", fv, stall, frame_count);
        end
        enable = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL disable_stall: stall=%b in LEAD with enable=0, required 0", stall);
        end
        enable = 1'b1;
    endtask

    task automatic test_async_reset();
        int w;
        send(`DTYPE_ROW_START, 16'h0, w);
        send(`DTYPE_PIXEL, 16'h0345, w);
        #2;
        resetb_clki = 1'b0;
        #1;
        checks++;
        if ({fv, lv, dvo, stall, protocol_err, datao, frame_count} !== 33'd0) begin
            errors++;
            $display("FAIL async_reset: fv/lv/dvo/stall/err=%b%b%b%b%b datao=%h fc=%0d, required all 0",
                     fv, lv, dvo, stall, protocol_err, datao, frame_count);
        end
        @(negedge clki);
        resetb_clki = 1'b1;
        tick(2);
        checks++;
        if ({fv, lv, dvo, stall} !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle: fv/lv/dvo/stall=%b%b%b%b, required 0000", fv, lv, dvo, stall);
        end
    endtask

    initial begin
        enable = 1'b1;
        left_justify = 1'b0;
        vlead = 16'd1; hblank = 16'd1; vtrail = 16'd1; vblank = 16'd1;
        dvi = 1'b0;
        dtypei = '0;
        datai = '0;
        test_reset();
        test_basic_frame();
        test_implicit();
        test_justify();
        test_headers();
        test_errors_and_disable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
